// File: rtl/fifo_credit_push.sv
// -----------------------------------------------------------------------------
// fifo_credit_push
//
// Write-end flow controller for a one-hot-pointer FIFO that sits one or more
// register stages away from its producer. The FIFO's ready is not looked at.
// Instead, a local credit counter starts at the FIFO depth. Each accepted item
// spends one credit, and each pop reported back from the far end returns one.
// Accepted items reach the FIFO through a single registered stage.
//
// Ports:
//   clk          clock; all state updates on posedge
//   rst_n        asynchronous active-low reset
//   valid_flush  synchronous flush, shared with the downstream FIFO
//   in_data      upstream payload
//   in_valid     upstream has a payload
//   in_ready     this block accepts in_data this cycle (registered state only)
//   push_data    payload to the FIFO push_data
//   push         push strobe to the FIFO push
//   credit_ret   one credit returned (FIFO-side pop, possibly registered)
//   credit_cnt   free-slot count as seen by this block
//   idle         nothing in flight and all credits home
//   err_ovf      sticky: a credit came back while the counter was already full
// -----------------------------------------------------------------------------
module fifo_credit_push #(
    parameter int DW      = 64,
    parameter int CREDITS = 4,
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_flush,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] push_data,
    output logic          push,
    input  logic          credit_ret,
    output logic [CW-1:0] credit_cnt,
    output logic          idle,
    output logic          err_ovf
);

    localparam logic [CW-1:0] CNT_FULL = CW'(CREDITS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_q;
    logic [DW-1:0] data_q;
    logic          err_q, err_d;
    logic          acc;
    logic          ovf;

    // in_ready depends only on the counter register, so in_valid has no
    // combinational path back to in_ready.
    assign in_ready = (cnt_q != '0);
    assign acc      = in_valid & in_ready & ~valid_flush;

    // A credit that arrives while the counter is already full, with no
    // accept to spend one, cannot be right. Hold at full and flag it.
    assign ovf = credit_ret & ~acc & (cnt_q == CNT_FULL);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        cnt_d = cnt_q;
        err_d = err_q | ovf;
        if (valid_flush) begin
            cnt_d = CNT_FULL;
            err_d = 1'b0;
        end else if (acc && !credit_ret) begin
            cnt_d = cnt_q - 1'b1;
        end else if (!acc && credit_ret && !ovf) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values no matter how the blocks are ordered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= CNT_FULL;
            push_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            push_q <= acc;
            err_q  <= err_d;
        end
    end

    // NOTE: the payload register has no reset. push qualifies it, so a reset
    // here would only cost reset routing to a wide datapath.
    always_ff @(posedge clk) begin
        if (acc) begin
            data_q <= in_data;
        end
    end

    assign push       = push_q;
    assign push_data  = data_q;
    assign credit_cnt = cnt_q;
    assign err_ovf    = err_q;
    assign idle       = (cnt_q == CNT_FULL) & ~push_q;

endmodule

// File: tb/tb_fifo_credit_push.sv
// -----------------------------------------------------------------------------
// tb_fifo_credit_push
//
// Directed table-driven bench for fifo_credit_push (DW=8, CREDITS=4).
// Each vector holds the inputs for one cycle and the outputs expected just
// after the next rising edge. A small occupancy model of the downstream FIFO
// pops on credit_ret. This model checks the credit invariant on every falling
// edge, and it flags any push into a full FIFO.
// -----------------------------------------------------------------------------
module tb_fifo_credit_push;

    localparam int DW      = 8;
    localparam int CREDITS = 4;
    localparam int CW      = $clog2(CREDITS + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_flush;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] push_data;
    logic          push;
    logic          credit_ret;
    logic [CW-1:0] credit_cnt;
    logic          idle;
    logic          err_ovf;

    int total = 0;
    int bad   = 0;
    int occ   = 0;

    always #5 clk = ~clk;

    fifo_credit_push #(.DW(DW), .CREDITS(CREDITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_flush(valid_flush),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .push_data  (push_data),
        .push       (push),
        .credit_ret (credit_ret),
        .credit_cnt (credit_cnt),
        .idle       (idle),
        .err_ovf    (err_ovf)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Downstream FIFO occupancy: it pops on credit_ret when non-empty, it
    // writes on push, and it clears on flush and reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ = 0;
        end else if (valid_flush) begin
            occ = 0;
        end else begin
            if (push) check("push_into_full_fifo", 64'(occ == CREDITS && !credit_ret), 64'd0);
            if (credit_ret && occ > 0) occ = occ - 1;
            if (push) occ = occ + 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1)
            check("credit_invariant", 64'(int'(credit_cnt) + occ + int'(push)), 64'(CREDITS));
    end

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          cr;
        logic          fl;
        logic          e_push;
        logic [DW-1:0] e_data;
        logic [CW-1:0] e_cnt;
        logic          e_rdy;
        logic          e_idle;
        logic          e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [DW-1:0] d, logic cr, logic fl,
                                logic ep, logic [DW-1:0] ed, int ec,
                                logic er, logic ei, logic ee);
        vec_t t;
        t.v = v; t.d = d; t.cr = cr; t.fl = fl;
        t.e_push = ep; t.e_data = ed; t.e_cnt = CW'(ec);
        t.e_rdy = er; t.e_idle = ei; t.e_err = ee;
        return t;
    endfunction

    task automatic check_outs(input string tag, input logic ep, input logic [DW-1:0] ed,
                              input int ec, input logic er, input logic ei, input logic ee);
        check({tag, ".push"}, 64'(push), 64'(ep));
        if (ep) check({tag, ".push_data"}, 64'(push_data), 64'(ed));
        check({tag, ".credit_cnt"}, 64'(credit_cnt), 64'(ec));
        check({tag, ".in_ready"}, 64'(in_ready), 64'(er));
        check({tag, ".idle"}, 64'(idle), 64'(ei));
        check({tag, ".err_ovf"}, 64'(err_ovf), 64'(ee));
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic cr, input logic fl);
        in_valid = v; in_data = d; credit_ret = cr; valid_flush = fl;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);

        //           v  data  cr fl  push data  cnt rdy idle err
        // Fill with the FIFO never popped: A0..A3 pushed, then stall at 0.
        vecs.push_back(mk(1, 8'hA0, 0, 0, 1, 8'hA0, 3, 1, 0, 0));
        vecs.push_back(mk(1, 8'hA1, 0, 0, 1, 8'hA1, 2, 1, 0, 0));
        vecs.push_back(mk(1, 8'hA2, 0, 0, 1, 8'hA2, 1, 1, 0, 0));
        vecs.push_back(mk(1, 8'hA3, 0, 0, 1, 8'hA3, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'hA4, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        vecs.push_back(mk(1, 8'hA4, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        // One pop at cnt=0: the counter rises, and ready only comes back after the edge.
        vecs.push_back(mk(1, 8'hA4, 1, 0, 0, 8'h00, 1, 1, 0, 0));
        vecs.push_back(mk(1, 8'hA4, 0, 0, 1, 8'hA4, 0, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0));
        // Drain two so that cnt=2.
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 1, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 2, 1, 0, 0));
        // Steady stream where each accept coincides with a credit return.
        vecs.push_back(mk(1, 8'hB0, 1, 0, 1, 8'hB0, 2, 1, 0, 0));
        vecs.push_back(mk(1, 8'hB1, 1, 0, 1, 8'hB1, 2, 1, 0, 0));
        vecs.push_back(mk(1, 8'hB2, 1, 0, 1, 8'hB2, 2, 1, 0, 0));
        vecs.push_back(mk(1, 8'hB3, 1, 0, 1, 8'hB3, 2, 1, 0, 0));
        // Drain everything.
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 3, 1, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 4, 1, 1, 0));
        // Spurious credit at full: saturate, sticky error, then flush clears it.
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 4, 1, 1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 4, 1, 1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0, 8'h00, 4, 1, 1, 0));
        // Two items, then flush with in_valid and credit_ret both high.
        vecs.push_back(mk(1, 8'hC0, 0, 0, 1, 8'hC0, 3, 1, 0, 0));
        vecs.push_back(mk(1, 8'hC1, 0, 0, 1, 8'hC1, 2, 1, 0, 0));
        vecs.push_back(mk(1, 8'hC2, 1, 1, 0, 8'h00, 4, 1, 1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 4, 1, 1, 0));

        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        check_outs("reset", 1'b0, '0, CREDITS, 1'b1, 1'b1, 1'b0);

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].cr, vecs[i].fl);
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].e_push, vecs[i].e_data,
                       int'(vecs[i].e_cnt), vecs[i].e_rdy, vecs[i].e_idle, vecs[i].e_err);
            if (vecs[i].fl) check($sformatf("vec%0d.fifo_empty", i), 64'(occ), 64'd0);
        end

        // Asynchronous reset mid-stream with cnt=1 and push=1.
        drive(1'b1, 8'hE0, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hE1, 1'b0, 1'b0); tick();
        drive(1'b1, 8'hE2, 1'b0, 1'b0); tick();
        check_outs("pre_rst", 1'b1, 8'hE2, 1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 8'hE3, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, '0, CREDITS, 1'b1, 1'b1, 1'b0);
        tick();
        check_outs("rst_held", 1'b0, '0, CREDITS, 1'b1, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        drive(1'b1, 8'hF0, 1'b0, 1'b0); tick();
        check_outs("post_rst_first", 1'b1, 8'hF0, 3, 1'b1, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0); tick();
        check_outs("post_rst_quiet", 1'b0, '0, 3, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
